// File: rtl/mips_defs.sv
// Shared definitions for the MIPS execute stage: ALU codes, funct codes,
// forwarding selects and the multiply/divide state encoding.
package mips_defs;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

    // Forwarding mux; the unused select 11 falls back to the register value.
    function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                            input logic [31:0] reg_v,
                                            input logic [31:0] w_v,
                                            input logic [31:0] m_v);
        case (sel)
            FWD_W:   return w_v;
            FWD_M:   return m_v;
            default: return reg_v;
        endcase
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 32-step multiply/divide unit with HI/LO registers.
// Works on operand magnitudes; signs are applied on the final step.
module mul_div_unit
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  md_op_t      i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    md_state_t   r_state;
    logic [4:0]  r_count;
    logic [63:0] r_acc;     // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] r_opb;     // multiplicand or divisor magnitude
    logic        r_is_div;
    logic        r_neg_q;   // negate product / quotient
    logic        r_neg_r;   // negate remainder (sign of dividend)
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic        w_div;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;

    assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
    assign w_div    = (i_op == MD_DIV)  || (i_op == MD_DIVU);
    assign w_mag_a  = (w_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
    assign w_mag_b  = (w_signed && i_b[31]) ? (32'd0 - i_b) : i_b;

    logic [32:0] w_mul_sum;
    logic [32:0] w_rem_sh;
    logic [32:0] w_rem_diff;
    logic [63:0] w_acc_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // One shift-add or restoring-subtract step, plus sign-corrected results
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
        w_rem_sh   = {r_acc[63:32], r_acc[31]};
        w_rem_diff = w_rem_sh - {1'b0, r_opb};
        if (r_is_div) begin
            // bit 32 of the difference is the borrow: restore on borrow
            if (w_rem_diff[32])
                w_acc_nxt = {w_rem_sh[31:0], r_acc[30:0], 1'b0};
            else
                w_acc_nxt = {w_rem_diff[31:0], r_acc[30:0], 1'b1};
        end else begin
            w_acc_nxt = {w_mul_sum, r_acc[31:1]};
        end
        w_prod = r_neg_q ? (64'd0 - w_acc_nxt) : w_acc_nxt;
        w_quot = r_neg_q ? (32'd0 - w_acc_nxt[31:0])  : w_acc_nxt[31:0];
        w_rem  = r_neg_r ? (32'd0 - w_acc_nxt[63:32]) : w_acc_nxt[63:32];
    end

    // Control FSM: launch in IDLE, 32 iteration steps in BUSY, then write HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= MD_IDLE;
            r_count  <= 5'd0;
            r_acc    <= 64'd0;
            r_opb    <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else if (r_state == MD_IDLE) begin
            if (i_start) begin
                r_state  <= MD_BUSY;
                r_count  <= 5'd0;
                r_acc    <= {32'd0, w_mag_a};
                r_opb    <= w_mag_b;
                r_is_div <= w_div;
                r_neg_q  <= w_signed && (i_a[31] ^ i_b[31]);
                r_neg_r  <= w_signed && i_a[31];
            end else begin
                if (i_mthi) r_hi <= i_wdata;
                if (i_mtlo) r_lo <= i_wdata;
            end
        end else begin
            r_acc   <= w_acc_nxt;
            r_count <= r_count + 5'd1;
            if (r_count == 5'd31) begin
                r_state <= MD_IDLE;
                if (r_is_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quot;
                end else begin
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
                end
            end
        end
    end

    assign o_busy = (r_state == MD_BUSY);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/exec_stage.sv
// MIPS execute stage: operand forwarding, ALU, destination select and the
// multiply/divide unit with its stall request to the hazard unit.
module exec_stage
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  alu_ctrl_e,
    input  logic        alu_src_e,
    input  logic        reg_dst_e,
    input  logic [31:0] rd1_e,
    input  logic [31:0] rd2_e,
    input  logic [4:0]  rt_e,
    input  logic [4:0]  rd_e,
    input  logic [31:0] sign_imm_e,
    input  logic [31:0] instr_e,
    input  logic [1:0]  forward_a_e,
    input  logic [1:0]  forward_b_e,
    input  logic [31:0] alu_out_m,
    input  logic [31:0] result_w,
    output logic [31:0] alu_out_e,
    output logic [31:0] write_data_e,
    output logic [4:0]  write_reg_e,
    output logic        zero_e,
    output logic        md_stall
);

    logic [31:0] w_src_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_src_b;
    logic [31:0] w_alu_res;

    assign w_src_a      = fwd_sel(forward_a_e, rd1_e, result_w, alu_out_m);
    assign w_fwd_b      = fwd_sel(forward_b_e, rd2_e, result_w, alu_out_m);
    assign w_src_b      = alu_src_e ? sign_imm_e : w_fwd_b;
    assign write_data_e = w_fwd_b;
    assign write_reg_e  = reg_dst_e ? rd_e : rt_e;

    // ALU; slt compares as signed, add/sub simply wrap
    always_comb begin
        w_alu_res = 32'd0;
        case (alu_ctrl_e)
            ALU_ADD: w_alu_res = w_src_a + w_src_b;
            ALU_SUB: w_alu_res = w_src_a - w_src_b;
            ALU_AND: w_alu_res = w_src_a & w_src_b;
            ALU_OR:  w_alu_res = w_src_a | w_src_b;
            ALU_SLT: w_alu_res = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
            default: w_alu_res = 32'd0;
        endcase
    end

    assign zero_e = (w_alu_res == 32'd0);

    logic        w_rtype;
    logic [5:0]  w_funct;
    logic        w_start;
    logic        w_md_any;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_mfhi;
    logic        w_mflo;
    md_op_t      w_md_op;
    logic        w_unused;

    assign w_rtype  = (instr_e[31:26] == OP_RTYPE);
    assign w_funct  = instr_e[5:0];
    assign w_unused = ^instr_e[25:6];

    // Decode MD instructions (R-type only)
    always_comb begin
        w_start = 1'b0;
        w_mthi  = 1'b0;
        w_mtlo  = 1'b0;
        w_mfhi  = 1'b0;
        w_mflo  = 1'b0;
        w_md_op = MD_MULT;
        if (w_rtype) begin
            case (w_funct)
                FN_MULT:  begin w_start = 1'b1; w_md_op = MD_MULT;  end
                FN_MULTU: begin w_start = 1'b1; w_md_op = MD_MULTU; end
                FN_DIV:   begin w_start = 1'b1; w_md_op = MD_DIV;   end
                FN_DIVU:  begin w_start = 1'b1; w_md_op = MD_DIVU;  end
                FN_MTHI:  w_mthi = 1'b1;
                FN_MTLO:  w_mtlo = 1'b1;
                FN_MFHI:  w_mfhi = 1'b1;
                FN_MFLO:  w_mflo = 1'b1;
                default:  ;
            endcase
        end
    end

    assign w_md_any = w_start | w_mthi | w_mtlo | w_mfhi | w_mflo;

    logic        w_busy;
    logic [31:0] w_hi;
    logic [31:0] w_lo;

    mul_div_unit u_md (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_op    (w_md_op),
        .i_a     (w_src_a),
        .i_b     (w_fwd_b),
        .i_mthi  (w_mthi),
        .i_mtlo  (w_mtlo),
        .i_wdata (w_src_a),
        .o_busy  (w_busy),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );

    // Only MD instructions wait for the unit; everything else flows past it
    assign md_stall  = w_busy & w_md_any;
    assign alu_out_e = w_mfhi ? w_hi : (w_mflo ? w_lo : w_alu_res);

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: ALU/forwarding cases and MD timing.
module tb_exec_stage;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  alu_ctrl_e;
    logic        alu_src_e, reg_dst_e;
    logic [31:0] rd1_e, rd2_e, sign_imm_e, instr_e, alu_out_m, result_w;
    logic [4:0]  rt_e, rd_e;
    logic [1:0]  forward_a_e, forward_b_e;
    logic [31:0] alu_out_e, write_data_e;
    logic [4:0]  write_reg_e;
    logic        zero_e, md_stall;

    always #5 clk = ~clk;

    exec_stage dut (
        .clk(clk), .rst_n(rst_n), .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e),
        .reg_dst_e(reg_dst_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .rt_e(rt_e), .rd_e(rd_e),
        .sign_imm_e(sign_imm_e), .instr_e(instr_e), .forward_a_e(forward_a_e),
        .forward_b_e(forward_b_e), .alu_out_m(alu_out_m), .result_w(result_w),
        .alu_out_e(alu_out_e), .write_data_e(write_data_e), .write_reg_e(write_reg_e),
        .zero_e(zero_e), .md_stall(md_stall)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
        chk(tag, got, e);
    endtask

    function automatic logic [31:0] r_instr(input logic [5:0] fn);
        return {26'd0, fn};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_ctrl_e = ALU_ADD; alu_src_e = 1'b0; reg_dst_e = 1'b0;
        rd1_e = 32'd0; rd2_e = 32'd0; rt_e = 5'd0; rd_e = 5'd0;
        sign_imm_e = 32'd0; instr_e = 32'd0; forward_a_e = FWD_REG; forward_b_e = FWD_REG;
        alu_out_m = 32'd0; result_w = 32'd0;
    endtask

    // Reference arithmetic for HI/LO
    task automatic md_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo);
        longint      p;
        logic [63:0] pu;
        int          sa, sb;
        sa = a; sb = b;
        hi = 32'd0; lo = 32'd0;
        case (fn)
            FN_MULT:  begin p = longint'(sa) * longint'(sb); hi = p[63:32]; lo = p[31:0]; end
            FN_MULTU: begin pu = {32'd0, a} * {32'd0, b}; hi = pu[63:32]; lo = pu[31:0]; end
            FN_DIVU:  if (b == 0) begin lo = 32'hFFFFFFFF; hi = a; end
                      else begin lo = a / b; hi = a % b; end
            FN_DIV:   if (b == 0) begin lo = a[31] ? 32'd1 : 32'hFFFFFFFF; hi = a; end
                      else begin lo = sa / sb; hi = sa % sb; end
            default:  ;
        endcase
    endtask

    task automatic alu_case(input string tag, input logic [2:0] ctrl,
                            input logic [1:0] fa, input logic [1:0] fb, input logic src,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] m, input logic [31:0] w, input logic [31:0] imm,
                            input logic rdst,
                            input logic [31:0] e_alu, input logic [31:0] e_wd,
                            input logic e_zero, input logic [4:0] e_wr);
        cyc();
        instr_e = r_instr(6'h20); alu_ctrl_e = ctrl; forward_a_e = fa; forward_b_e = fb;
        alu_src_e = src; rd1_e = a; rd2_e = b; alu_out_m = m; result_w = w;
        sign_imm_e = imm; reg_dst_e = rdst; rt_e = 5'd3; rd_e = 5'd7;
        sb_q.push_back(e_alu); sb_q.push_back(e_wd);
        sb_q.push_back({31'd0, e_zero}); sb_q.push_back({27'd0, e_wr});
        #2;
        chk_pop({tag, "_alu"}, alu_out_e);
        chk_pop({tag, "_wdata"}, write_data_e);
        chk_pop({tag, "_zero"}, {31'd0, zero_e});
        chk_pop({tag, "_wreg"}, {27'd0, write_reg_e});
        chk({tag, "_stall"}, {31'd0, md_stall}, 32'd0);
    endtask

    // Launch an MD op, then hold 'hold' in E for the 32 busy cycles
    task automatic run_md(input string tag, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hold, input logic hold_stall);
        logic [31:0] hi, lo;
        cyc();
        instr_e = r_instr(fn); rd1_e = a; rd2_e = b;
        forward_a_e = FWD_REG; forward_b_e = FWD_REG;
        md_model(fn, a, b, hi, lo);
        sb_q.push_back(hi); sb_q.push_back(lo);
        #2;
        chk({tag, "_launch_stall"}, {31'd0, md_stall}, 32'd0);
        for (int k = 1; k <= 32; k++) begin
            cyc();
            instr_e = hold; rd1_e = $urandom; rd2_e = $urandom;
            #2;
            chk($sformatf("%s_busy_stall_%0d", tag, k), {31'd0, md_stall}, {31'd0, hold_stall});
        end
    endtask

    task automatic read_hilo(input string tag);
        cyc();
        instr_e = r_instr(FN_MFHI);
        #2;
        chk({tag, "_rd_stall"}, {31'd0, md_stall}, 32'd0);
        chk_pop({tag, "_hi"}, alu_out_e);
        cyc();
        instr_e = r_instr(FN_MFLO);
        #2;
        chk_pop({tag, "_lo"}, alu_out_e);
    endtask

    initial begin
        logic [31:0] drop;
        idle_inputs();
        instr_e = r_instr(FN_MFHI);
        #2;
        chk("rst_stall", {31'd0, md_stall}, 32'd0);
        chk("rst_hi", alu_out_e, 32'd0);
        instr_e = r_instr(FN_MFLO);
        #1;
        chk("rst_lo", alu_out_e, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ALU and forwarding
        alu_case("add_fwd_m", ALU_ADD, FWD_M, FWD_REG, 1'b0, 32'd99, 32'd7, 32'd5, 32'd0, 32'd0,
                 1'b1, 32'd12, 32'd7, 1'b0, 5'd7);
        alu_case("slt_neg", ALU_SLT, FWD_REG, FWD_REG, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0,
                 1'b0, 32'd1, 32'd1, 1'b0, 5'd3);
        alu_case("slt_pos", ALU_SLT, FWD_REG, FWD_REG, 1'b0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0,
                 1'b0, 32'd0, 32'hFFFFFFFF, 1'b1, 5'd3);
        alu_case("sub_fwd_w", ALU_SUB, FWD_REG, FWD_W, 1'b0, 32'd20, 32'd9, 32'd0, 32'd20, 32'd0,
                 1'b1, 32'd0, 32'd20, 1'b1, 5'd7);
        alu_case("and_imm", ALU_AND, FWD_REG, FWD_REG, 1'b1, 32'h0000FFFF, 32'h1234, 32'd0, 32'd0,
                 32'h00000F0F, 1'b1, 32'h00000F0F, 32'h1234, 1'b0, 5'd7);
        alu_case("or_fwd11", ALU_OR, 2'b11, 2'b11, 1'b0, 32'hF0, 32'h0F, 32'h1, 32'h2, 32'd0,
                 1'b0, 32'hFF, 32'h0F, 1'b0, 5'd3);
        alu_case("sub_wrap", ALU_SUB, FWD_REG, FWD_REG, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0,
                 1'b0, 32'hFFFFFFFE, 32'd5, 1'b0, 5'd3);

        // Multiply / divide
        run_md("mult", FN_MULT, 32'hFFFFFFFE, 32'd3, r_instr(FN_MFHI), 1'b1);
        read_hilo("mult");
        run_md("divu0", FN_DIVU, 32'd7, 32'd0, r_instr(FN_MFLO), 1'b1);
        read_hilo("divu0");
        run_md("div", FN_DIV, 32'hFFFFFFF9, 32'd2, r_instr(FN_MULT), 1'b1);
        read_hilo("div");
        run_md("div0neg", FN_DIV, 32'hFFFFFFF8, 32'd0, r_instr(FN_MTHI), 1'b1);
        read_hilo("div0neg");
        run_md("multu", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, r_instr(FN_DIVU), 1'b1);
        read_hilo("multu");
        run_md("mult_add", FN_MULT, 32'h00012345, 32'hFFFF0001, r_instr(6'h20), 1'b0);
        read_hilo("mult_add");
        // bubble (clr) after launch: the operation still completes on time
        run_md("mult_clr", FN_MULT, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1'b0);
        read_hilo("mult_clr");
        // back-to-back: second mult held through the first, then launches
        run_md("b2b_1", FN_MULT, 32'd5, 32'd6, r_instr(FN_MULT), 1'b1);
        drop = sb_q.pop_front();
        drop = sb_q.pop_front();
        run_md("b2b_2", FN_MULT, 32'd7, 32'hFFFFFFF7, r_instr(FN_MFLO), 1'b1);
        read_hilo("b2b_2");

        // mthi / mtlo
        cyc();
        instr_e = r_instr(FN_MTHI); rd1_e = 32'h1234; forward_a_e = FWD_REG;
        #2;
        chk("mthi_stall", {31'd0, md_stall}, 32'd0);
        cyc();
        instr_e = r_instr(FN_MFHI);
        sb_q.push_back(32'h1234);
        #2;
        chk("mfhi_after_mthi_stall", {31'd0, md_stall}, 32'd0);
        chk_pop("mfhi_after_mthi", alu_out_e);
        cyc();
        instr_e = r_instr(FN_MTLO); rd1_e = 32'd0; forward_a_e = FWD_W; result_w = 32'hCAFE0001;
        cyc();
        instr_e = r_instr(FN_MFLO); forward_a_e = FWD_REG;
        sb_q.push_back(32'hCAFE0001);
        #2;
        chk_pop("mflo_after_mtlo", alu_out_e);

        // reset in the middle of a multiply
        cyc();
        instr_e = r_instr(FN_MULT); rd1_e = 32'd1000; rd2_e = 32'd1000;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            instr_e = r_instr(FN_MFHI);
        end
        #2;
        chk("pre_rst_stall", {31'd0, md_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, md_stall}, 32'd0);
        chk("mid_rst_hi", alu_out_e, 32'd0);
        instr_e = r_instr(FN_MFLO);
        #1;
        chk("mid_rst_lo", alu_out_e, 32'd0);
        cyc();
        rst_n = 1'b1;
        run_md("post_rst", FN_MULT, 32'hFFFFFF00, 32'hFFFFFF00, r_instr(FN_MFHI), 1'b1);
        read_hilo("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
